prog_loader: RTL and testbench

//  Byte-stream boot sequencer feeding the single-cycle core's setup interface.

---
 rtl/prog_loader.sv | 237 +++++++++++++++++++++++
 tb/tb_prog_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream boot sequencer: parses INST/REG/START frames from a byte source and
// drives the core's instruction-memory writes, register preloads and PC start address.
module prog_loader #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned MAX_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_setup,
  output logic        o_inst_we,
  output logic [31:0] o_inst_addr,
  output logic [31:0] o_inst_data,
  output logic        o_reg_we,
  output logic [4:0]  o_reg_addr,
  output logic [31:0] o_reg_data,
  output logic [31:0] o_start_addr,
  output logic        o_running,
  output logic        o_err
);

  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    C_NONE  = 2'd0,
    C_INST  = 2'd1,
    C_REG   = 2'd2,
    C_START = 2'd3
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [39:0]   hdr_q, hdr_d;
  logic [23:0]   word_q, word_d;
  logic [31:0]   waddr_q, waddr_d;
  logic [15:0]   left_q, left_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [31:0]   inst_addr_q, inst_addr_d;
  logic [31:0]   inst_data_q, inst_data_d;
  logic [4:0]    reg_addr_q, reg_addr_d;
  logic [31:0]   reg_data_q, reg_data_d;
  logic [31:0]   start_q, start_d;

  logic        accept;
  logic [47:0] hdr_full;
  logic [31:0] word_full;
  logic [2:0]  hdr_last;
  logic        tmo_hit;

  // NOTE: state is written only here, with non-blocking assignments, so every
  // register samples the same pre-edge values computed by the comb block below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= C_NONE;
      cnt_q       <= '0;
      hdr_q       <= '0;
      word_q      <= '0;
      waddr_q     <= '0;
      left_q      <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      inst_addr_q <= '0;
      inst_data_q <= '0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      start_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      word_q      <= word_d;
      waddr_q     <= waddr_d;
      left_q      <= left_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      inst_addr_q <= inst_addr_d;
      inst_data_q <= inst_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      start_q     <= start_d;
    end
  end

  assign o_rx_ready = (state_q == S_IDLE) || (state_q == S_HDR) || (state_q == S_DATA);
  assign accept     = i_rx_valid && o_rx_ready;
  // Fields arrive little-endian, so new bytes enter at the top and slide down.
  assign hdr_full   = {i_rx_data, hdr_q};
  assign word_full  = {i_rx_data, word_q};
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CYC));

  always_comb begin
    unique case (cmd_q)
      C_INST:  hdr_last = 3'd5;
      C_START: hdr_last = 3'd3;
      default: hdr_last = 3'd0;
    endcase
  end

  always_comb begin
    // NOTE: every _d gets its hold value first; a path that skips an assignment
    // would otherwise infer a latch.
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    word_d      = word_q;
    waddr_d     = waddr_q;
    left_d      = left_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    inst_addr_d = inst_addr_q;
    inst_data_d = inst_data_q;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    start_d     = start_q;

    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        cnt_d = '0;
        if (accept) begin
          if (i_rx_data >= 8'h01 && i_rx_data <= 8'h03) begin
            cmd_d   = cmd_t'(i_rx_data[1:0]);
            err_d   = 1'b0;
            state_d = S_HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_HDR: begin
        if (accept) begin
          hdr_d = hdr_full[47:8];
          cnt_d = cnt_q + 3'd1;
          tmo_d = '0;
          if (cnt_q == hdr_last) begin
            cnt_d   = '0;
            state_d = S_IDLE;
            unique case (cmd_q)
              C_INST: begin
                if (hdr_full[1:0] != 2'b00 ||
                    {16'd0, hdr_full[47:32]} > MAX_WORDS) begin
                  err_d = 1'b1;
                end else if (hdr_full[47:32] != 16'd0) begin
                  waddr_d = hdr_full[31:0];
                  left_d  = hdr_full[47:32];
                  state_d = S_DATA;
                end
              end
              C_REG: begin
                if (i_rx_data[7:5] != 3'b000) err_d = 1'b1;
                else                          state_d = S_DATA;
              end
              C_START: begin
                if (hdr_full[17:16] != 2'b00) begin
                  err_d = 1'b1;
                end else begin
                  start_d = hdr_full[47:16];
                  state_d = S_RUN;
                end
              end
              default: err_d = 1'b1;
            endcase
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_DATA: begin
        if (accept) begin
          word_d = word_full[31:8];
          cnt_d  = cnt_q + 3'd1;
          tmo_d  = '0;
          if (cnt_q == 3'd3) begin
            cnt_d   = '0;
            state_d = S_WRITE;
            // Output address/data load together with the strobe and then hold.
            if (cmd_q == C_INST) begin
              inst_addr_d = waddr_q;
              inst_data_d = word_full;
              waddr_d     = waddr_q + 32'd4;
              left_d      = left_q - 16'd1;
            end else begin
              reg_addr_d = hdr_q[36:32];
              reg_data_d = word_full;
            end
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_WRITE: begin
        tmo_d   = '0;
        state_d = (cmd_q == C_INST && left_q != 16'd0) ? S_DATA : S_IDLE;
      end

      S_RUN: state_d = S_RUN;

      default: state_d = S_IDLE;
    endcase
  end

  assign o_setup      = (state_q != S_RUN);
  assign o_running    = (state_q == S_RUN);
  assign o_inst_we    = (state_q == S_WRITE) && (cmd_q == C_INST);
  assign o_reg_we     = (state_q == S_WRITE) && (cmd_q == C_REG);
  assign o_inst_addr  = inst_addr_q;
  assign o_inst_data  = inst_data_q;
  assign o_reg_addr   = reg_addr_q;
  assign o_reg_data   = reg_data_q;
  assign o_start_addr = start_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are driven byte by byte and every
// expected value below is hand-derived from the frame contents.
module tb_prog_loader;

  localparam int unsigned TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, setup, inst_we, reg_we, running, err;
  logic [31:0] inst_addr, inst_data, reg_data, start_addr;
  logic [4:0]  reg_addr;

  int total = 0;
  int bad   = 0;
  int n_inst = 0;
  int n_reg  = 0;

  prog_loader #(.TIMEOUT_CYC(TMO), .MAX_WORDS(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_rx_ready   (rx_ready),
    .o_setup      (setup),
    .o_inst_we    (inst_we),
    .o_inst_addr  (inst_addr),
    .o_inst_data  (inst_data),
    .o_reg_we     (reg_we),
    .o_reg_addr   (reg_addr),
    .o_reg_data   (reg_data),
    .o_start_addr (start_addr),
    .o_running    (running),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && inst_we) n_inst++;
    if (!rst && reg_we)  n_reg++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Holds valid until the loader takes the byte; returns 1 ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
    end
    #1 rx_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $error("FAIL send_byte: byte %h not accepted, ready stayed %b", b, ok);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)));
  endtask

  task automatic push_raw(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_setup",  32'(setup), 32'd1);
    check("rst_ready",  32'(rx_ready), 32'd1);
    check("rst_run",    32'(running), 32'd0);
    check("rst_err",    32'(err), 32'd0);
    check("rst_iwe",    32'(inst_we), 32'd0);
    check("rst_start",  start_addr, 32'h0);
    check("rst_iaddr",  inst_addr, 32'h0);

    // INST: two words at 0x0
    send_byte(8'h01); send_word(32'h0000_0000); send_byte(8'h02); send_byte(8'h00);
    send_word(32'h0000_0013);
    check("i1_we",    32'(inst_we), 32'd1);
    check("i1_addr",  inst_addr, 32'h0);
    check("i1_data",  inst_data, 32'h0000_0013);
    check("i1_ready", 32'(rx_ready), 32'd0);
    send_word(32'h0010_0093);
    check("i2_we",   32'(inst_we), 32'd1);
    check("i2_addr", inst_addr, 32'h4);
    check("i2_data", inst_data, 32'h0010_0093);
    idle(1);
    check("i2_we_off",  32'(inst_we), 32'd0);
    check("i2_hold",    inst_addr, 32'h4);
    check("i_count",    32'(n_inst), 32'd2);
    check("i_setup",    32'(setup), 32'd1);
    check("i_err",      32'(err), 32'd0);

    // REG preload
    send_byte(8'h02); send_byte(8'h05);
    check("r_addr_pre", 32'(reg_addr), 32'd0);
    send_word(32'hDEAD_BEEF);
    check("r_we",    32'(reg_we), 32'd1);
    check("r_iwe",   32'(inst_we), 32'd0);
    check("r_addr",  32'(reg_addr), 32'd5);
    check("r_data",  reg_data, 32'hDEAD_BEEF);
    idle(1);
    check("r_count", 32'(n_reg), 32'd1);

    // Unknown command sets error; next valid command byte clears it
    send_byte(8'h7F);
    check("bad_cmd_err", 32'(err), 32'd1);
    send_byte(8'h02);
    check("err_clear", 32'(err), 32'd0);
    send_byte(8'h1F); send_word(32'h1234_5678);
    check("r2_we",   32'(reg_we), 32'd1);
    check("r2_addr", 32'(reg_addr), 32'd31);
    check("r2_data", reg_data, 32'h1234_5678);
    idle(1);

    // Unaligned INST address
    send_byte(8'h01); send_word(32'h0000_0002); send_byte(8'h01); send_byte(8'h00);
    idle(1);
    check("unal_err",   32'(err), 32'd1);
    check("unal_count", 32'(n_inst), 32'd2);

    // Count above MAX_WORDS
    send_byte(8'h01); send_word(32'h0000_0000); send_byte(8'h01); send_byte(8'h04);
    check("max_err", 32'(err), 32'd1);

    // Count exactly MAX_WORDS is accepted; abandoned frame then times out in DATA
    send_byte(8'h01); send_word(32'h0000_0000); send_byte(8'h00); send_byte(8'h04);
    check("max_ok_err",   32'(err), 32'd0);
    check("max_ok_ready", 32'(rx_ready), 32'd1);
    idle(TMO + 1);
    check("data_tmo_err", 32'(err), 32'd1);

    // Count zero: no write, back to IDLE
    send_byte(8'h01); send_word(32'h0000_0040); send_byte(8'h00); send_byte(8'h00);
    idle(2);
    check("cnt0_err",   32'(err), 32'd0);
    check("cnt0_count", 32'(n_inst), 32'd2);

    // Header timeout: exactly TMO idle cycles is fine, one more aborts
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(TMO);
    check("tmo_edge_err", 32'(err), 32'd0);
    idle(1);
    check("tmo_err", 32'(err), 32'd1);
    send_byte(8'h02); send_byte(8'h03); send_word(32'hCAFE_0001);
    check("tmo_rec_we",   32'(reg_we), 32'd1);
    check("tmo_rec_addr", 32'(reg_addr), 32'd3);
    check("tmo_rec_err",  32'(err), 32'd0);
    idle(1);

    // REG index out of range, then x0 forwarded untouched
    send_byte(8'h02); send_byte(8'h20);
    check("ridx_err", 32'(err), 32'd1);
    send_byte(8'h02); send_byte(8'h00); send_word(32'h0000_0001);
    check("r0_addr", 32'(reg_addr), 32'd0);
    check("r0_data", reg_data, 32'h1);
    idle(1);
    check("r_total", 32'(n_reg), 32'd4);

    // Reset mid-DATA of an INST frame
    send_byte(8'h01); send_word(32'h0000_0010); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mrst_setup", 32'(setup), 32'd1);
    check("mrst_ready", 32'(rx_ready), 32'd1);
    check("mrst_iaddr", inst_addr, 32'h0);
    check("mrst_idata", inst_data, 32'h0);
    check("mrst_raddr", 32'(reg_addr), 32'd0);
    check("mrst_rdata", reg_data, 32'h0);
    check("mrst_err",   32'(err), 32'd0);
    n_inst = 0;
    send_byte(8'h01); send_word(32'h0000_0000); send_byte(8'h01); send_byte(8'h00);
    send_word(32'h1122_3344);
    check("mrst_we",   32'(inst_we), 32'd1);
    check("mrst_addr", inst_addr, 32'h0);
    check("mrst_data", inst_data, 32'h1122_3344);
    idle(1);

    // Address wraps at 32 bits without error
    send_byte(8'h01); send_word(32'hFFFF_FFFC); send_byte(8'h02); send_byte(8'h00);
    send_word(32'hAAAA_AAAA);
    check("wrap1_addr", inst_addr, 32'hFFFF_FFFC);
    send_word(32'hBBBB_BBBB);
    check("wrap2_addr", inst_addr, 32'h0);
    check("wrap2_data", inst_data, 32'hBBBB_BBBB);
    check("wrap_err",   32'(err), 32'd0);
    idle(1);
    check("wrap_count", 32'(n_inst), 32'd3);

    // Unaligned START address is rejected
    send_byte(8'h03); send_word(32'h0000_0101);
    check("sunal_err", 32'(err), 32'd1);
    check("sunal_run", 32'(running), 32'd0);

    // START enters RUN; bytes are ignored afterwards
    send_byte(8'h03); send_word(32'h0000_0100);
    check("st_addr",  start_addr, 32'h0000_0100);
    check("st_setup", 32'(setup), 32'd0);
    check("st_run",   32'(running), 32'd1);
    check("st_ready", 32'(rx_ready), 32'd0);
    check("st_err",   32'(err), 32'd0);
    push_raw(8'h01);
    for (int i = 0; i < 10; i++) push_raw(8'h00);
    push_raw(8'h02); push_raw(8'h05);
    for (int i = 0; i < 4; i++) push_raw(8'h11);
    idle(3);
    check("run_inst", 32'(n_inst), 32'd3);
    check("run_reg",  32'(n_reg), 32'd4);
    check("run_stay", 32'(running), 32'd1);
    check("run_addr", start_addr, 32'h0000_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
